note_player: RTL and testbench
==============================

# note_player

Playback back-end that consumes the note stream read out of the recording memory and turns it into a square-wave audio signal. It pulls one note word per step over a valid/ready handshake and sounds it for a fixed number of clock cycles. It decodes pitch class and octave into a half-period divider and drives a 1-bit audio pin. It is the consumer on the other side of the memory's `note` output, where the recorder is the producer on the `key` side.

## Interface
Parameters:
- word_size, 8, width of a note word; must be ≥ 8, bits above [7] ignored
- TICKS_PER_STEP, 6250000, cycles each note sounds (1/16 s at 100 MHz); must be ≥ 16
- STEP_W, 23, width of step counter; must hold TICKS_PER_STEP-1

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- play  in  1  1 = run, 0 = pause
- in_note  in  word_size  note word from memory
- in_valid  in  1  in_note is valid
- in_ready  out  1  player accepts a note this cycle
- audio  out  1  square-wave speaker output
- playing  out  1  a note or rest is currently sounding
- cur_note  out  8  registered copy of the note being sounded
- step_done  out  1  one-cycle pulse on the last cycle of each step

## Operation
- Note encoding:
  - [3:0] pitch class: 0 = C … 11 = B; 12–15 = rest.
  - [6:4] octave 0–7.
  - [7] reserved, ignored.
- Half period = BASE_HALF[pitch] >> octave, 22-bit unsigned.
  - BASE_HALF values: C0 = 3058104, A0 = 1818182. Full table: 100 MHz / (2·f_octave0).
- FSM states:
  - IDLE: in_ready = 0. Goes to FETCH when play = 1.
  - FETCH: in_ready = play. On in_valid & in_ready, latch cur_note, load the divider, clear the step counter, go to PLAY. If play = 0, go to IDLE.
  - PLAY: the step counter increments every cycle. At count = TICKS_PER_STEP-1, pulse step_done and go to FETCH. If play = 0, go to PAUSE.
  - PAUSE: step and divider counters freeze and audio is held 0. When play = 1, return to PLAY and resume the frozen counts.
- Audio generation:
  - audio = 0 at note start.
  - audio toggles each time the divider reaches half period - 1; the divider then reloads to 0.
  - For a rest, audio stays 0 for the whole step and playing = 1.
- playing = 1 only in PLAY.

## Timing
- Reset values: state IDLE, in_ready = 0, audio = 0, playing = 0, cur_note = 0, step_done = 0, all counters 0.
- Reset asserted mid-note takes effect at the next edge. No partial step completes.
- Handshake at edge t:
  - PLAY, playing = 1 and the new cur_note are visible from t+1.
  - The first audio rise occurs half-period cycles after t+1.
- A step lasts exactly TICKS_PER_STEP cycles in PLAY, and step_done is high during the last of them.
- in_ready rises the cycle after step_done. Back-to-back period is therefore TICKS_PER_STEP + 1 cycles.
- in_valid = 0 in FETCH: wait indefinitely with audio 0 and playing = 0.
- play falling in the same cycle as step_done: the step completes and the FSM goes to FETCH, where in_ready = 0, then to IDLE.
- Counter rules:
  - The divider counter is 22 bits and never wraps, because it reloads at its terminal count.
  - The step counter saturates to 0 on completion.

## Configuration
- NOTE_PLAYER_ARTIC_EN defined: audio is forced 0 during the final TICKS_PER_STEP/8 cycles (integer divide) of each step. Repeated identical notes are then audibly separated. playing and step_done are unaffected.
- NOTE_PLAYER_ARTIC_EN not defined: the tone sounds for the full step.

## Structure
- Package note_player_pkg holds:
  - the FSM state enum (IDLE, FETCH, PLAY, PAUSE);
  - the pitch/octave field positions;
  - the REST threshold (12);
  - the 12-entry BASE_HALF table.
- Sub-module pitch_divider: 22-bit half-period counter plus audio toggle flip-flop, with load, enable (freeze) and force-low inputs.
- The top level holds the FSM, the step counter and the handshake.

## Test plan
- Reset mid-PLAY:
  - Stimulus: assert reset for one cycle while in PLAY.
  - Required response: next cycle audio = 0, playing = 0, in_ready = 0, cur_note = 0, state IDLE.
- Single note:
  - Stimulus: TICKS_PER_STEP = 200000, note 0x49 (A4), handshake at t.
  - Required response: audio period is 227272 cycles (half period 113636); step_done at t+200000; in_ready at t+200001.
- Rest:
  - Stimulus: note 0x0C.
  - Required response: audio stays 0 for the whole step, playing = 1, step_done fires on schedule.
- Pause:
  - Stimulus: drop play 1000 cycles into a note 0x70 (C7, half period 23891), hold 500 cycles, resume.
  - Required response: audio is 0 during the pause; step_done is delayed by exactly 500 cycles.
- Back-to-back with in_valid held high:
  - Stimulus: present three notes.
  - Required response: handshakes are exactly TICKS_PER_STEP + 1 cycles apart; cur_note sequence matches the input.
- Articulation (TICKS_PER_STEP = 160, with NOTE_PLAYER_ARTIC_EN defined):
  - Required response: audio is 0 for the last 20 cycles of each step.
  - Without NOTE_PLAYER_ARTIC_EN, audio continues toggling through those cycles.

Source files
------------

// File: rtl/note_player_pkg.sv
// note_player_pkg: shared types, note-word field layout and the octave-0
// half-period table used by the note player.
package note_player_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    PLAY  = 2'd2,
    PAUSE = 2'd3
  } state_t;

  // Note word layout: [3:0] pitch class, [6:4] octave, [7] reserved
  localparam int unsigned PITCH_LSB = 0;
  localparam int unsigned PITCH_W   = 4;
  localparam int unsigned OCT_LSB   = 4;
  localparam int unsigned OCT_W     = 3;
  localparam int unsigned NOTE_W    = 8;
  localparam int unsigned HALF_W    = 22;

  // Pitch classes at or above this value are rests
  localparam logic [PITCH_W-1:0] REST_PITCH = 4'd12;

  // Half period in 100 MHz cycles for each octave-0 pitch, C0 .. B0
  localparam logic [HALF_W-1:0] BASE_HALF [0:11] = '{
    22'd3058104,  // C
    22'd2886836,  // C#
    22'd2724796,  // D
    22'd2570694,  // D#
    22'd2427184,  // E
    22'd2290426,  // F
    22'd2162630,  // F#
    22'd2040816,  // G
    22'd1926040,  // G#
    22'd1818182,  // A
    22'd1715854,  // A#
    22'd1619695   // B
  };

  // Half period for a pitch/octave pair; 0 marks a rest (silent)
  function automatic logic [HALF_W-1:0] half_period(input logic [PITCH_W-1:0] pitch,
                                                    input logic [OCT_W-1:0]   octave);
    logic [HALF_W-1:0] base;
    base = '0;
    if (pitch < REST_PITCH) base = BASE_HALF[pitch];
    return base >> octave;
  endfunction

endpackage

// File: rtl/note_player_divider.sv
// pitch_divider: half-period counter and audio toggle flip-flop.
// load restarts the tone low, enable advances the counter (deasserted =
// freeze), keep = 0 forces the registered audio pin low without
// disturbing the tone phase. A half period of 0 is silent.
module pitch_divider
  import note_player_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              enable,
  input  logic              keep,
  input  logic [HALF_W-1:0] half,
  output logic              audio
);

  logic [HALF_W-1:0] cnt;
  logic [HALF_W-1:0] cnt_next;
  logic              tone;
  logic              tone_next;

  // Next counter/tone: reload at terminal count so the counter never wraps
  always_comb begin
    cnt_next  = cnt;
    tone_next = tone;
    if (load) begin
      cnt_next  = '0;
      tone_next = 1'b0;
    end else if (enable && (half != '0)) begin
      if (cnt == half - HALF_W'(1)) begin
        cnt_next  = '0;
        tone_next = ~tone;
      end else begin
        cnt_next = cnt + HALF_W'(1);
      end
    end
  end

  // Counter, tone phase and gated audio pin registers
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= '0;
      tone  <= 1'b0;
      audio <= 1'b0;
    end else begin
      cnt   <= cnt_next;
      tone  <= tone_next;
      audio <= tone_next & keep;
    end
  end

endmodule

// File: rtl/note_player.sv
// note_player: pulls note words over valid/ready, sounds each for
// TICKS_PER_STEP cycles as a square wave on audio.
// Optional macro NOTE_PLAYER_ARTIC_EN: silence the last TICKS_PER_STEP/8
// cycles of every step so repeated notes are separated.
module note_player
  import note_player_pkg::*;
#(
  parameter int unsigned word_size      = 8,
  parameter int unsigned TICKS_PER_STEP = 6250000,
  parameter int unsigned STEP_W         = 23
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 play,
  input  logic [word_size-1:0] in_note,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 audio,
  output logic                 playing,
  output logic [NOTE_W-1:0]    cur_note,
  output logic                 step_done
);

  localparam logic [STEP_W-1:0] STEP_LAST  = STEP_W'(TICKS_PER_STEP - 1);
  localparam logic [STEP_W-1:0] STEP_PRE   = STEP_W'(TICKS_PER_STEP - 2);
  localparam logic [STEP_W-1:0] ARTIC_FROM = STEP_W'(TICKS_PER_STEP - TICKS_PER_STEP / 8);

  state_t            state;
  logic [STEP_W-1:0] step_cnt;

  logic              accept_c;
  logic              last_c;
  logic              to_play_c;
  logic [STEP_W-1:0] step_next_c;
  logic              keep_c;
  logic [HALF_W-1:0] half_c;

  // Divider controls derived from the state being entered next cycle
  assign accept_c    = (state == FETCH) && in_valid && in_ready;
  assign last_c      = (step_cnt == STEP_LAST);
  assign to_play_c   = ((state == PLAY) && play && !last_c) || ((state == PAUSE) && play);
  assign step_next_c = (state == PLAY) ? step_cnt + STEP_W'(1) : step_cnt;
  assign half_c      = half_period(cur_note[PITCH_LSB +: PITCH_W], cur_note[OCT_LSB +: OCT_W]);

`ifdef NOTE_PLAYER_ARTIC_EN
  assign keep_c = to_play_c && (step_next_c < ARTIC_FROM);
`else
  assign keep_c = to_play_c;
`endif

  // Player FSM with step counter, handshake and registered status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      step_cnt  <= '0;
      in_ready  <= 1'b0;
      playing   <= 1'b0;
      cur_note  <= '0;
      step_done <= 1'b0;
    end else begin
      step_done <= 1'b0;
      case (state)
        IDLE: begin
          playing  <= 1'b0;
          in_ready <= play;
          if (play) state <= FETCH;
        end
        FETCH: begin
          if (accept_c) begin
            state    <= PLAY;
            in_ready <= 1'b0;
            playing  <= 1'b1;
            cur_note <= in_note[NOTE_W-1:0];
            step_cnt <= '0;
          end else if (!play) begin
            state    <= IDLE;
            in_ready <= 1'b0;
          end else begin
            in_ready <= 1'b1;
          end
        end
        PLAY: begin
          if (last_c) begin
            // Step always completes, even if play drops on its last cycle
            state    <= FETCH;
            step_cnt <= '0;
            playing  <= 1'b0;
            in_ready <= play;
          end else begin
            step_cnt <= step_next_c;
            if (play) begin
              step_done <= (step_cnt == STEP_PRE);
            end else begin
              state   <= PAUSE;
              playing <= 1'b0;
            end
          end
        end
        PAUSE: begin
          if (play) begin
            state     <= PLAY;
            playing   <= 1'b1;
            step_done <= last_c;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  pitch_divider u_div (
    .clk    (clk),
    .reset  (reset),
    .load   (accept_c),
    .enable (state == PLAY),
    .keep   (keep_c),
    .half   (half_c),
    .audio  (audio)
  );

endmodule

// File: tb/tb_note_player.sv
// Directed bench for note_player with a 16000-cycle step.
// Audio expectations in the articulation window follow NOTE_PLAYER_ARTIC_EN.
module tb_note_player;

  localparam int unsigned T = 16000;
`ifdef NOTE_PLAYER_ARTIC_EN
  localparam logic ARTIC = 1'b1;
`else
  localparam logic ARTIC = 1'b0;
`endif
  // Expected audio where a high tone overlaps the last T/8 cycles
  localparam logic TAIL_HI = ~ARTIC;

  logic       clk = 1'b0;
  logic       reset;
  logic       play;
  logic [7:0] in_note;
  logic       in_valid;
  logic       in_ready;
  logic       audio;
  logic       playing;
  logic [7:0] cur_note;
  logic       step_done;

  int checks = 0;
  int errors = 0;
  int edges  = 0;

  note_player #(
    .word_size      (8),
    .TICKS_PER_STEP (T),
    .STEP_W         (14)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .play      (play),
    .in_note   (in_note),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .audio     (audio),
    .playing   (playing),
    .cur_note  (cur_note),
    .step_done (step_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edges <= edges + 1;

  // Advance to 1 time unit after rising edge number e
  task automatic wait_to(input int e);
    while (edges < e) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int t;
    int t2;
    int t3;
    int p;
    int r;

    reset = 1'b1; play = 1'b0; in_valid = 1'b0; in_note = 8'h00;
    wait_to(2);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_audio", 32'(audio), 0);
    chk("rst_playing", 32'(playing), 0);
    chk("rst_cur_note", 32'(cur_note), 0);
    chk("rst_step_done", 32'(step_done), 0);

    // IDLE -> FETCH, wait with no valid note
    reset = 1'b0; play = 1'b1;
    wait_to(3);
    chk("fetch_ready", 32'(in_ready), 1);
    wait_to(8);
    chk("fetch_wait_ready", 32'(in_ready), 1);
    chk("fetch_wait_playing", 32'(playing), 0);
    chk("fetch_wait_audio", 32'(audio), 0);

    // Note 1: B7 (half 12653), in_valid held high for three notes
    in_valid = 1'b1; in_note = 8'h7B;
    t = edges + 1;
    wait_to(t);
    chk("n1_playing", 32'(playing), 1);
    chk("n1_cur_note", 32'(cur_note), 32'h7B);
    chk("n1_ready_low", 32'(in_ready), 0);
    chk("n1_audio_start", 32'(audio), 0);
    in_note = 8'h0C;
    wait_to(t + 12652);
    chk("n1_before_rise", 32'(audio), 0);
    wait_to(t + 12653);
    chk("n1_rise", 32'(audio), 1);
    wait_to(t + 13999);
    chk("n1_pre_tail", 32'(audio), 1);
    wait_to(t + 14000);
    chk("n1_tail_start", 32'(audio), 32'(TAIL_HI));
    wait_to(t + 15998);
    chk("n1_done_early", 32'(step_done), 0);
    wait_to(t + 15999);
    chk("n1_step_done", 32'(step_done), 1);
    chk("n1_tail_end", 32'(audio), 32'(TAIL_HI));
    chk("n1_playing_last", 32'(playing), 1);
    wait_to(t + 16000);
    chk("n1_ready_after", 32'(in_ready), 1);
    chk("n1_done_clear", 32'(step_done), 0);
    chk("n1_playing_fetch", 32'(playing), 0);
    chk("n1_audio_fetch", 32'(audio), 0);
    chk("n1_note_hold", 32'(cur_note), 32'h7B);

    // Note 2: rest, handshake exactly T+1 after the first
    t2 = t + T + 1;
    wait_to(t2);
    chk("n2_cur_note", 32'(cur_note), 32'h0C);
    chk("n2_playing", 32'(playing), 1);
    in_note = 8'h79;
    wait_to(t2 + 12653);
    chk("rest_audio_mid", 32'(audio), 0);
    wait_to(t2 + 15999);
    chk("rest_step_done", 32'(step_done), 1);
    chk("rest_audio_end", 32'(audio), 0);
    chk("rest_playing", 32'(playing), 1);

    // Note 3: A7 (half 14204), rise lands inside the tail window
    t3 = t2 + T + 1;
    wait_to(t3);
    chk("n3_cur_note", 32'(cur_note), 32'h79);
    in_valid = 1'b0;
    wait_to(t3 + 14203);
    chk("n3_before_rise", 32'(audio), 0);
    wait_to(t3 + 14204);
    chk("n3_rise", 32'(audio), 32'(TAIL_HI));
    wait_to(t3 + 15999);
    chk("n3_step_done", 32'(step_done), 1);
    wait_to(t3 + 16005);
    chk("starve_ready", 32'(in_ready), 1);
    chk("starve_playing", 32'(playing), 0);
    chk("starve_audio", 32'(audio), 0);

    // Pause: B7, drop play at count 12000 for 500 cycles
    in_valid = 1'b1; in_note = 8'h7B;
    p = edges + 1;
    wait_to(p);
    chk("pz_cur_note", 32'(cur_note), 32'h7B);
    in_valid = 1'b0;
    wait_to(p + 11999);
    play = 1'b0;
    wait_to(p + 12000);
    chk("pz_playing", 32'(playing), 0);
    wait_to(p + 12200);
    chk("pz_audio", 32'(audio), 0);
    chk("pz_ready", 32'(in_ready), 0);
    wait_to(p + 12499);
    play = 1'b1;
    wait_to(p + 12500);
    chk("pz_resume", 32'(playing), 1);
    wait_to(p + 13152);
    chk("pz_before_rise", 32'(audio), 0);
    wait_to(p + 13153);
    chk("pz_rise", 32'(audio), 1);
    wait_to(p + 16498);
    chk("pz_done_early", 32'(step_done), 0);
    wait_to(p + 16499);
    chk("pz_step_done", 32'(step_done), 1);

    // play drops in the step_done cycle: FETCH without ready, then IDLE
    play = 1'b0;
    wait_to(p + 16500);
    chk("drop_ready_fetch", 32'(in_ready), 0);
    chk("drop_playing", 32'(playing), 0);
    wait_to(p + 16501);
    chk("drop_ready_idle", 32'(in_ready), 0);

    // Reset in the middle of a note
    play = 1'b1; in_valid = 1'b1; in_note = 8'h2A;
    wait_to(p + 16502);
    chk("rp_ready", 32'(in_ready), 1);
    r = edges + 1;
    wait_to(r);
    chk("rp_cur_note", 32'(cur_note), 32'h2A);
    chk("rp_playing", 32'(playing), 1);
    wait_to(r + 99);
    reset = 1'b1;
    wait_to(r + 100);
    chk("rp_audio", 32'(audio), 0);
    chk("rp_playing0", 32'(playing), 0);
    chk("rp_ready0", 32'(in_ready), 0);
    chk("rp_cur_note0", 32'(cur_note), 0);
    chk("rp_step_done0", 32'(step_done), 0);
    reset = 1'b0; play = 1'b0; in_valid = 1'b0;
    wait_to(r + 103);
    chk("rp_idle_ready", 32'(in_ready), 0);
    chk("rp_idle_playing", 32'(playing), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
